// File: rtl/input_logic_rmw_mem_datos.sv
// Store path of the MEM stage. Turns SB/SH/SW requests into word writes to the
// data memory. Sub-word stores use a read-modify-write sequence:
// READ, then WAIT (capture the read word), then WRITE the merged word.
// Optional macro STORE_BYTE_ENABLE_EN adds the o_mem_byte_en port. With it
// defined, every aligned store is a single write with lane-replicated data.
module input_logic_rmw_mem_datos #(
  parameter int INPUT_OUTPUT_LENGTH             = 32,
  parameter int CANT_BITS_SELECT_BYTES_MEM_DATA = 3,
  parameter int CANT_COLUMNAS_MEM_DATOS         = 4,
  parameter int CANT_BITS_ADDR                  = 11
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic                                       i_valid,
  input  logic [CANT_BITS_SELECT_BYTES_MEM_DATA-1:0] i_select_op,
  input  logic [CANT_BITS_ADDR-1:0]                  i_address_word,
  input  logic [$clog2(CANT_COLUMNAS_MEM_DATOS)-1:0] i_address_mem_LSB,
  input  logic [INPUT_OUTPUT_LENGTH-1:0]             i_dato,
  input  logic [INPUT_OUTPUT_LENGTH-1:0]             i_mem_rdata,
  output logic [CANT_BITS_ADDR-1:0]                  o_mem_addr,
  output logic                                       o_mem_re,
  output logic                                       o_mem_we,
  output logic [INPUT_OUTPUT_LENGTH-1:0]             o_mem_wdata,
  output logic                                       o_busy,
  output logic                                       o_done,
  output logic                                       o_misaligned
`ifdef STORE_BYTE_ENABLE_EN
  ,
  output logic [CANT_COLUMNAS_MEM_DATOS-1:0]         o_mem_byte_en
`endif
);

  localparam int W     = INPUT_OUTPUT_LENGTH;
  localparam int COL   = CANT_COLUMNAS_MEM_DATOS;
  localparam int LSB_W = $clog2(CANT_COLUMNAS_MEM_DATOS);

  localparam logic [1:0] SZ_NONE = 2'd0;
  localparam logic [1:0] SZ_BYTE = 2'd1;
  localparam logic [1:0] SZ_HALF = 2'd2;
  localparam logic [1:0] SZ_WORD = 2'd3;

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

  state_t              state_q, state_d;
  logic [CANT_BITS_ADDR-1:0] addr_q, addr_d;
  logic [LSB_W-1:0]    lsb_q, lsb_d;
  logic [1:0]          size_q, size_d;
  logic [W-1:0]        dato_q, dato_d;
  logic [W-1:0]        rdata_q, rdata_d;

  logic [1:0]          req_size;
  logic                req_misaligned;

  // The sign bit of the select only matters for loads.
  logic unused_sign;
  assign unused_sign = i_select_op[CANT_BITS_SELECT_BYTES_MEM_DATA-1];

  assign req_size       = i_select_op[1:0];
  assign req_misaligned = ((req_size == SZ_HALF) && i_address_mem_LSB[0]) ||
                          ((req_size == SZ_WORD) && (i_address_mem_LSB != '0));

  // State and captured request. Reset drops any in-flight request.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lsb_q   <= '0;
      size_q  <= '0;
      dato_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lsb_q   <= lsb_d;
      size_q  <= size_d;
      dato_q  <= dato_d;
      rdata_q <= rdata_d;
    end
  end

  // Next state: requests are only looked at in IDLE, so i_valid while busy is dropped.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lsb_d   = lsb_q;
    size_d  = size_q;
    dato_d  = dato_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid && (req_size != SZ_NONE)) begin
          addr_d = i_address_word;
          lsb_d  = i_address_mem_LSB;
          size_d = req_size;
          dato_d = i_dato;
          if (req_misaligned)
            state_d = ERR;
`ifdef STORE_BYTE_ENABLE_EN
          else
            state_d = WRITE;
`else
          else if (req_size == SZ_WORD)
            state_d = WRITE;
          else
            state_d = READ;
`endif
        end
      end
      READ:  state_d = WAIT;
      WAIT: begin
        // Read data arrives one cycle after the read strobe.
        rdata_d = i_mem_rdata;
        state_d = WRITE;
      end
      WRITE: state_d = IDLE;
      ERR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef STORE_BYTE_ENABLE_EN
  logic unused_rdata;
  assign unused_rdata = ^{i_mem_rdata, rdata_q};
`endif

  // Outputs decode the registered state; write data is formed only in WRITE.
  always_comb begin
    logic [W-1:0] mask;
    logic [W-1:0] lane;
    o_mem_re     = (state_q == READ);
    o_mem_we     = (state_q == WRITE);
    o_done       = (state_q == WRITE);
    o_misaligned = (state_q == ERR);
    o_busy       = (state_q != IDLE);
    o_mem_addr   = (state_q != IDLE) ? addr_q : '0;
    o_mem_wdata  = '0;
    mask         = '0;
    lane         = '0;
`ifdef STORE_BYTE_ENABLE_EN
    o_mem_byte_en = '0;
    if (state_q == WRITE) begin
      unique case (size_q)
        SZ_BYTE: begin
          o_mem_wdata   = {COL{dato_q[7:0]}};
          o_mem_byte_en = COL'(1) << lsb_q;
        end
        SZ_HALF: begin
          o_mem_wdata   = {(COL/2){dato_q[15:0]}};
          o_mem_byte_en = COL'(3) << lsb_q;
        end
        default: begin
          o_mem_wdata   = dato_q;
          o_mem_byte_en = '1;
        end
      endcase
    end
`else
    if (state_q == WRITE) begin
      unique case (size_q)
        SZ_BYTE: begin
          mask = W'(8'hFF) << {lsb_q, 3'b000};
          lane = W'(dato_q[7:0]) << {lsb_q, 3'b000};
          o_mem_wdata = (rdata_q & ~mask) | (lane & mask);
        end
        SZ_HALF: begin
          mask = W'(16'hFFFF) << {lsb_q[LSB_W-1:1], 4'b0000};
          lane = W'(dato_q[15:0]) << {lsb_q[LSB_W-1:1], 4'b0000};
          o_mem_wdata = (rdata_q & ~mask) | (lane & mask);
        end
        default: o_mem_wdata = dato_q;
      endcase
    end
`endif
  end

endmodule
